mmio_bus_fabric: RTL and testbench

//  Parametrised memory-mapped I/O fabric between the CPU data port and NUM_SLAVES peripherals.

---
 rtl/mmio_pkg.sv | 27 ++
 rtl/mmio_err_status.sv | 47 ++++
 rtl/mmio_bus_fabric.sv | 168 ++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus fabric: FSM states, status-slave
// register offsets and the packed error-information word.
package mmio_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } fsm_state_t;

    localparam logic [1:0] STATUS_ADDR_OFF = 2'd0;
    localparam logic [1:0] STATUS_INFO_OFF = 2'd1;

    localparam int unsigned ERR_CNT_W  = 16;
    localparam int unsigned ERR_INFO_W = 32;

    typedef struct packed {
        logic [ERR_CNT_W-1:0] cnt;
        logic                 we;
        logic                 sticky;
    } err_info_t;

    // Status word layout as seen by the CPU: {cnt, 14'b0, we, sticky}
    function automatic logic [ERR_INFO_W-1:0] pack_err_info(input err_info_t info);
        return {info.cnt, 14'b0, info.we, info.sticky};
    endfunction

endpackage

// File: rtl/mmio_err_status.sv
// Bus-error capture registers and the read/clear mux of the built-in status slave.
module mmio_err_status
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] capture_addr_i,
    input  logic              capture_we_i,
    input  logic              clear_i,
    input  logic [1:0]        rd_off_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [ADDR_W-1:0] err_addr_q;
    err_info_t         info_q;

    // Capture takes priority; a clear never coincides with a capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_q <= '0;
            info_q     <= '0;
        end else if (capture_i) begin
            err_addr_q    <= capture_addr_i;
            info_q.sticky <= 1'b1;
            info_q.we     <= capture_we_i;
            if (info_q.cnt != '1) begin
                info_q.cnt <= info_q.cnt + ERR_CNT_W'(1);
            end
        end else if (clear_i) begin
            info_q <= '0;
        end
    end

    always_comb begin
        rdata_c_o = '0;
        case (rd_off_i)
            STATUS_ADDR_OFF: rdata_c_o = DATA_W'(err_addr_q);
            STATUS_INFO_OFF: rdata_c_o = DATA_W'(pack_err_info(info_q));
            default:         rdata_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// CPU-to-peripheral MMIO fabric: region decode, one-hot slave request with
// req/ack wait states, timeout watchdog and bus-error reporting.
module mmio_bus_fabric
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_LSB    = 7,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cpu_req_i,
    input  logic                         cpu_we_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]            cpu_wdata_i,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic                         cpu_stall_o,
    output logic                         cpu_err_o,
    output logic [NUM_SLAVES-1:0]        sl_req_o,
    output logic                         sl_we_o,
    output logic [ADDR_W-1:0]            sl_addr_o,
    output logic [DATA_W-1:0]            sl_wdata_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] sl_rdata_i,
    input  logic [NUM_SLAVES-1:0]        sl_ack_i
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT);

    fsm_state_t        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic [SEL_W-1:0]      sel_c;
    logic [SEL_W-1:0]      sel_eff;
    logic [NUM_SLAVES-1:0] req_hot;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_sel;

    logic              err_capture;
    logic [ADDR_W-1:0] err_cap_addr;
    logic              err_cap_we;
    logic              status_clear;
    logic [DATA_W-1:0] status_rdata;

    assign sel_c = cpu_addr_i[SEL_LSB +: SEL_W];

    // Slave steering follows the live address in IDLE and the latched select in WAIT.
    always_comb begin
        sel_eff   = (state_q == WAIT) ? sel_q : sel_c;
        req_hot   = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_eff == SEL_W'(i)) begin
                req_hot[i] = 1'b1;
                ack_sel    = sl_ack_i[i];
                rdata_sel  = sl_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        sel_d        = sel_q;
        sl_req_o     = '0;
        sl_we_o      = cpu_we_i;
        sl_addr_o    = cpu_addr_i;
        sl_wdata_o   = cpu_wdata_i;
        cpu_stall_o  = 1'b0;
        cpu_err_o    = 1'b0;
        cpu_rdata_o  = '0;
        err_capture  = 1'b0;
        err_cap_addr = cpu_addr_i;
        err_cap_we   = cpu_we_i;
        status_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (sel_c < SEL_W'(NUM_SLAVES)) begin
                        sl_req_o = req_hot;
                        if (ack_sel) begin
                            cpu_rdata_o = rdata_sel;
                        end else begin
                            cpu_stall_o = 1'b1;
                            addr_d      = cpu_addr_i;
                            wdata_d     = cpu_wdata_i;
                            we_d        = cpu_we_i;
                            sel_d       = sel_c;
                            wcnt_d      = '0;
                            state_d     = WAIT;
                        end
                    end else if (sel_c == SEL_W'(NUM_SLAVES)) begin
                        cpu_rdata_o  = status_rdata;
                        status_clear = cpu_we_i && (cpu_addr_i[3:2] == STATUS_INFO_OFF);
                    end else begin
                        cpu_err_o   = 1'b1;
                        err_capture = 1'b1;
                    end
                end
            end
            WAIT: begin
                sl_req_o   = req_hot;
                sl_we_o    = we_q;
                sl_addr_o  = addr_q;
                sl_wdata_o = wdata_q;
                if (ack_sel) begin
                    cpu_rdata_o = rdata_sel;
                    state_d     = IDLE;
                end else if (wcnt_q == WCNT_W'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1 this cycle: give up, report error.
                    cpu_err_o    = 1'b1;
                    err_capture  = 1'b1;
                    err_cap_addr = addr_q;
                    err_cap_we   = we_q;
                    state_d      = IDLE;
                end else begin
                    cpu_stall_o = 1'b1;
                    wcnt_d      = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mmio_err_status #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_err_status (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .capture_i      (err_capture),
        .capture_addr_i (err_cap_addr),
        .capture_we_i   (err_cap_we),
        .clear_i        (status_clear),
        .rd_off_i       (cpu_addr_i[3:2]),
        .rdata_c_o      (status_rdata)
    );

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric with per-slave programmable ack-delay models.
module tb_mmio_bus_fabric;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           cpu_req, cpu_we;
    logic [AW-1:0]  cpu_addr;
    logic [DW-1:0]  cpu_wdata, cpu_rdata;
    logic           cpu_stall, cpu_err;
    logic [NS-1:0]  sl_req, sl_ack;
    logic           sl_we;
    logic [AW-1:0]  sl_addr;
    logic [DW-1:0]  sl_wdata;
    logic [NS*DW-1:0] sl_rdata;

    int checks = 0;
    int errors = 0;

    int            delay [NS];
    int            cnt   [NS];
    logic [DW-1:0] srd   [NS];
    logic [DW-1:0] last_wr [NS];
    logic [NS-1:0] stray;

    always #5 clk = ~clk;

    mmio_bus_fabric #(
        .NUM_SLAVES (NS), .ADDR_W (AW), .DATA_W (DW),
        .SEL_LSB (7), .SEL_W (3), .TIMEOUT (16)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .cpu_req_i (cpu_req), .cpu_we_i (cpu_we), .cpu_addr_i (cpu_addr),
        .cpu_wdata_i (cpu_wdata), .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall), .cpu_err_o (cpu_err),
        .sl_req_o (sl_req), .sl_we_o (sl_we), .sl_addr_o (sl_addr),
        .sl_wdata_o (sl_wdata), .sl_rdata_i (sl_rdata), .sl_ack_i (sl_ack)
    );

    // Slave i acks after delay[i] cycles of continuous request (delay<0: never).
    always_comb begin
        sl_ack   = '0;
        sl_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            sl_ack[i] = stray[i] | (sl_req[i] && (delay[i] >= 0) && (cnt[i] == delay[i]));
            sl_rdata[i*DW +: DW] = srd[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst || !sl_req[i] || sl_ack[i]) cnt[i] <= 0;
            else                                cnt[i] <= cnt[i] + 1;
            if (sl_req[i] && sl_ack[i] && sl_we) last_wr[i] <= sl_wdata;
        end
    end

    task automatic set_cpu(input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // Single-cycle access issued at posedge+1, outputs sampled at the following negedge.
    task automatic one_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              output logic stall, output logic err,
                              output logic [DW-1:0] rdata, output logic [NS-1:0] req);
        set_cpu(1'b1, we, addr, wdata);
        @(negedge clk);
        stall = cpu_stall;
        err   = cpu_err;
        rdata = cpu_rdata;
        req   = sl_req;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        rst = 1'b1;
        set_cpu(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cpu_err); end
        checks++; if (sl_req !== 4'b0000) begin errors++; $display("FAIL reset_slreq got %b want 0000", sl_req); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        one_access(1'b0, 32'h200, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h want 0", rd); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_err_info got %h want 0", rd); end
    endtask

    task automatic test_zero_wait();
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        delay[0] = 0;
        srd[0]   = 32'h1234_5678;
        one_access(1'b0, 32'h0000_0004, '0, st, er, rd, rq);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL zw_stall got %b want 0", st); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL zw_rdata got %h want 12345678", rd); end
        checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL zw_slreq got %b want 0001", rq); end
        @(negedge clk);
        checks++; if (sl_req !== 4'b0000 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL idle_noreq slreq %b stall %b want 0000 0", sl_req, cpu_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_write();
        int nst = 0; logic done = 1'b0, hold_bad = 1'b0, e = 1'b0;
        delay[1] = 3;
        set_cpu(1'b1, 1'b1, 32'h0000_0084, 32'h0000_00A5);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (sl_req !== 4'b0010 || sl_wdata !== 32'hA5 || sl_we !== 1'b1 || sl_addr !== 32'h84) hold_bad = 1'b1;
            if (cpu_stall) nst++;
            else begin done = 1'b1; e = cpu_err; end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL ww_complete got stalled want done"); end
        checks++; if (nst != 3) begin errors++; $display("FAIL ww_stall_cycles got %0d want 3", nst); end
        checks++; if (hold_bad) begin errors++; $display("FAIL ww_hold got unstable want slreq=0010 wdata=a5"); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ww_err got %b want 0", e); end
        checks++; if (last_wr[1] !== 32'hA5) begin errors++; $display("FAIL ww_slave_data got %h want a5", last_wr[1]); end
    endtask

    task automatic test_timeout();
        int nst = 0; logic done = 1'b0, hold_bad = 1'b0, e = 1'b0;
        logic [DW-1:0] rfin = '1;
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        delay[2] = -1;
        stray    = 4'b1011;
        set_cpu(1'b1, 1'b0, 32'h0000_0104, '0);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (cpu_stall) begin
                nst++;
                if (sl_req !== 4'b0100) hold_bad = 1'b1;
            end else begin
                done = 1'b1; e = cpu_err; rfin = cpu_rdata;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        stray   = '0;
        checks++; if (!done) begin errors++; $display("FAIL to_complete got stalled want done"); end
        checks++; if (nst != 15) begin errors++; $display("FAIL to_stall_cycles got %0d want 15", nst); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", e); end
        checks++; if (rfin !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", rfin); end
        checks++; if (hold_bad) begin errors++; $display("FAIL to_slreq got unstable want 0100"); end
        @(negedge clk);
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b want 0", cpu_err); end
        @(posedge clk); #1;
        one_access(1'b0, 32'h200, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h104) begin errors++; $display("FAIL to_err_addr got %h want 104", rd); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0001_0001) begin errors++; $display("FAIL to_err_info got %h want 00010001", rd); end
    endtask

    task automatic test_unmapped();
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        one_access(1'b0, 32'h0000_0280, '0, st, er, rd, rq);
        checks++; if (er !== 1'b1 || st !== 1'b0) begin errors++; $display("FAIL um_err got err %b stall %b want 1 0", er, st); end
        checks++; if (rq !== 4'b0000) begin errors++; $display("FAIL um_slreq got %b want 0000", rq); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0002_0001) begin errors++; $display("FAIL um_cnt got %h want 00020001", rd); end
        one_access(1'b1, 32'h204, 32'hFFFF_FFFF, st, er, rd, rq);
        checks++; if (er !== 1'b0 || st !== 1'b0 || rq !== 4'b0000) begin
            errors++; $display("FAIL um_clear_access got err %b stall %b slreq %b want 0 0 0000", er, st, rq); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL um_cleared got %h want 0", rd); end
        one_access(1'b1, 32'h0000_0300, 32'h55, st, er, rd, rq);
        checks++; if (er !== 1'b1 || rq !== 4'b0000) begin errors++; $display("FAIL um_wr_err got err %b slreq %b want 1 0000", er, rq); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0001_0003) begin errors++; $display("FAIL um_wr_info got %h want 00010003", rd); end
        one_access(1'b0, 32'h200, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h300) begin errors++; $display("FAIL um_wr_addr got %h want 300", rd); end
        one_access(1'b0, 32'h208, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL um_other_off got %h want 0", rd); end
        one_access(1'b1, 32'h204, '0, st, er, rd, rq);
    endtask

    task automatic test_ack_on_timeout();
        int nst = 0; logic done = 1'b0, e = 1'b1;
        logic [DW-1:0] rfin = '0;
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        delay[3] = 15;
        srd[3]   = 32'hCAFE_F00D;
        set_cpu(1'b1, 1'b0, 32'h0000_0184, '0);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (cpu_stall) nst++;
            else begin done = 1'b1; e = cpu_err; rfin = cpu_rdata; end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL at_complete got stalled want done"); end
        checks++; if (nst != 15) begin errors++; $display("FAIL at_stall_cycles got %0d want 15", nst); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL at_err got %b want 0", e); end
        checks++; if (rfin !== 32'hCAFE_F00D) begin errors++; $display("FAIL at_rdata got %h want cafef00d", rfin); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL at_cnt got %h want 0", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic st, er; logic [DW-1:0] rd; logic [NS-1:0] rq;
        one_access(1'b0, 32'h0000_0280, '0, st, er, rd, rq);
        delay[2] = -1;
        set_cpu(1'b1, 1'b0, 32'h0000_0104, '0);
        repeat (2) begin @(posedge clk); #1; end
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (sl_req !== 4'b0100 || cpu_stall !== 1'b1) begin
            errors++; $display("FAIL rw_pending got slreq %b stall %b want 0100 1", sl_req, cpu_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sl_req !== 4'b0000 || cpu_stall !== 1'b0 || cpu_err !== 1'b0) begin
            errors++; $display("FAIL rw_abandon got slreq %b stall %b err %b want 0000 0 0", sl_req, cpu_stall, cpu_err); end
        @(posedge clk); #1;
        one_access(1'b0, 32'h200, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rw_err_addr got %h want 0", rd); end
        one_access(1'b0, 32'h204, '0, st, er, rd, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rw_err_info got %h want 0", rd); end
    endtask

    initial begin
        stray = '0;
        for (int i = 0; i < NS; i++) begin
            delay[i] = 0;
            srd[i]   = 32'h1000_0000 + DW'(i);
        end
        test_reset();
        test_zero_wait();
        test_wait_write();
        test_timeout();
        test_unmapped();
        test_ack_on_timeout();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
